// File: rtl/tlp_lane_realigner.sv
// Packs per-TLP dword runs from the straddle convertor into dense 512-bit beats
// that always start at dword 0, with a contiguous TKEEP on the final beat.
module tlp_lane_realigner #(
  parameter int KEEP_W = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [32*KEEP_W-1:0]  S_AXIS_TDATA,
  input  logic [KEEP_W-1:0]     S_AXIS_TKEEP,
  input  logic                  S_AXIS_TLAST,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  output logic [32*KEEP_W-1:0]  M_AXIS_TDATA,
  output logic [KEEP_W-1:0]     M_AXIS_TKEEP,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  error_keep_noncontig
);
  // state | meaning
  // RUN   | accepting input; residue holds fewer than 16 dwords of the TLP
  // FLUSH | TLP ended with more than 16 dwords; residue goes out as the last beat
  localparam int DATA_W = 32*KEEP_W;
  localparam logic [KEEP_W-1:0] ONE_K = {{(KEEP_W-1){1'b0}}, 1'b1};

  typedef enum logic {RUN, FLUSH} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   res_data, res_data_nxt;
  logic [4:0]          res_cnt, res_cnt_nxt;
  logic                m_valid, m_valid_nxt;
  logic [DATA_W-1:0]   m_data, m_data_nxt;
  logic [KEEP_W-1:0]   m_keep, m_keep_nxt;
  logic                m_last, m_last_nxt;
  logic                err, err_nxt;

  logic [3:0]          offset;
  logic [4:0]          n_dw;
  logic [KEEP_W-1:0]   keep_norm;
  logic                noncontig;
  logic [DATA_W-1:0]   in_shift;
  logic [DATA_W-1:0]   in_masked;
  logic [KEEP_W-1:0]   in_dw_mask;
  logic [2*DATA_W-1:0] comb_data;
  logic [5:0]          c_cnt;
  logic                out_free;
  logic                s_ready;
  logic                accept;

  function automatic logic [KEEP_W-1:0] low_mask(input logic [5:0] n);
    logic [KEEP_W:0] t;
    t = ({{KEEP_W{1'b0}}, 1'b1} << n) - {{KEEP_W{1'b0}}, 1'b1};
    return t[KEEP_W-1:0];
  endfunction

  always_comb begin
    offset = '0;
    n_dw   = '0;
    for (int i = KEEP_W-1; i >= 0; i--) begin
      if (S_AXIS_TKEEP[i]) offset = 4'(i);
      n_dw = n_dw + 5'(S_AXIS_TKEEP[i]);
    end
  end

  assign keep_norm  = S_AXIS_TKEEP >> offset;
  assign noncontig  = |(keep_norm & (keep_norm + ONE_K));
  assign in_shift   = S_AXIS_TDATA >> {offset, 5'b0};
  assign in_dw_mask = low_mask({1'b0, n_dw});

  // A non-contiguous beat is taken as N dwords from O, regardless of the holes.
  always_comb begin
    in_masked = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (in_dw_mask[i]) in_masked[32*i +: 32] = in_shift[32*i +: 32];
    end
  end

  // Residue dwords above res_cnt are kept zero so an OR builds the combined vector.
  assign comb_data = ({{DATA_W{1'b0}}, in_masked} << {res_cnt, 5'b0}) |
                     {{DATA_W{1'b0}}, res_data};
  assign c_cnt     = {1'b0, res_cnt} + {1'b0, n_dw};

  assign out_free = !m_valid || M_AXIS_TREADY;
  assign s_ready  = ARESETN && (state == RUN) && out_free;
  assign accept   = S_AXIS_TVALID && s_ready;

  always_comb begin
    state_nxt    = state;
    res_data_nxt = res_data;
    res_cnt_nxt  = res_cnt;
    m_valid_nxt  = m_valid && !M_AXIS_TREADY;
    m_data_nxt   = m_data;
    m_keep_nxt   = m_keep;
    m_last_nxt   = m_last;
    err_nxt      = accept && noncontig;
    case (state)
      RUN: begin
        if (accept) begin
          if (S_AXIS_TLAST && (c_cnt <= 6'd16)) begin
            res_data_nxt = '0;
            res_cnt_nxt  = '0;
            if (c_cnt != 6'd0) begin
              m_valid_nxt = 1'b1;
              m_data_nxt  = comb_data[DATA_W-1:0];
              m_keep_nxt  = low_mask(c_cnt);
              m_last_nxt  = 1'b1;
            end
          end else if (c_cnt >= 6'd16) begin
            m_valid_nxt  = 1'b1;
            m_data_nxt   = comb_data[DATA_W-1:0];
            m_keep_nxt   = '1;
            m_last_nxt   = 1'b0;
            res_data_nxt = comb_data[2*DATA_W-1:DATA_W];
            res_cnt_nxt  = 5'(c_cnt - 6'd16);
            if (S_AXIS_TLAST) state_nxt = FLUSH;
          end else begin
            res_data_nxt = comb_data[DATA_W-1:0];
            res_cnt_nxt  = c_cnt[4:0];
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          m_valid_nxt  = 1'b1;
          m_data_nxt   = res_data;
          m_keep_nxt   = low_mask({1'b0, res_cnt});
          m_last_nxt   = 1'b1;
          res_data_nxt = '0;
          res_cnt_nxt  = '0;
          state_nxt    = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state    <= RUN;
      res_data <= '0;
      res_cnt  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
      m_last   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      res_data <= res_data_nxt;
      res_cnt  <= res_cnt_nxt;
      m_valid  <= m_valid_nxt;
      m_data   <= m_data_nxt;
      m_keep   <= m_keep_nxt;
      m_last   <= m_last_nxt;
      err      <= err_nxt;
    end
  end

  assign S_AXIS_TREADY        = s_ready;
  assign M_AXIS_TDATA         = m_data;
  assign M_AXIS_TKEEP         = m_keep;
  assign M_AXIS_TLAST         = m_last;
  assign M_AXIS_TVALID        = m_valid;
  assign error_keep_noncontig = err;

endmodule

// File: tb/tb_tlp_lane_realigner.sv
// Bench for tlp_lane_realigner: directed test-plan cases plus random TLPs
// checked against a dword-queue packing model.
module tb_tlp_lane_realigner;
  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [511:0] S_AXIS_TDATA;
  logic [15:0]  S_AXIS_TKEEP;
  logic         S_AXIS_TLAST;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TREADY;
  logic [511:0] M_AXIS_TDATA;
  logic [15:0]  M_AXIS_TKEEP;
  logic         M_AXIS_TLAST;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY;
  logic         error_keep_noncontig;

  tlp_lane_realigner #(.KEEP_W(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .error_keep_noncontig(error_keep_noncontig)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [511:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  logic [31:0] tlp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          err_pulses = 0;
  bit          acc = 1'b0;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: handshakes are sampled on the falling edge, then step past the rising edge.
  task automatic tick();
    beat_t b;
    if (rand_ready) M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
    @(negedge ACLK);
    acc = 1'b0;
    if (ARESETN) begin
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        b.data = M_AXIS_TDATA;
        b.keep = M_AXIS_TKEEP;
        b.last = M_AXIS_TLAST;
        got_q.push_back(b);
      end
      acc = S_AXIS_TVALID && S_AXIS_TREADY;
      if (error_keep_noncontig) err_pulses++;
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic send(input logic [511:0] d, input logic [15:0] k, input logic l);
    int n;
    S_AXIS_TDATA  = d;
    S_AXIS_TKEEP  = k;
    S_AXIS_TLAST  = l;
    S_AXIS_TVALID = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < 200);
    check("send_accept", 512'(acc), 512'(1));
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic model_beat(input logic [511:0] d, input logic [15:0] k);
    for (int i = 0; i < 16; i++)
      if (k[i]) tlp_q.push_back(d[32*i +: 32]);
  endtask

  task automatic model_end();
    beat_t b;
    while (tlp_q.size() > 0) begin
      b.data = '0;
      b.keep = '0;
      for (int i = 0; i < 16 && tlp_q.size() > 0; i++) begin
        b.data[32*i +: 32] = tlp_q.pop_front();
        b.keep[i] = 1'b1;
      end
      b.last = (tlp_q.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string tag);
    beat_t e;
    beat_t g;
    int n;
    rand_ready = 1'b0;
    M_AXIS_TREADY = 1'b1;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({tag, "_count"}, 512'(got_q.size()), 512'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_data"}, g.data, e.data);
      check({tag, "_keep"}, 512'(g.keep), 512'(e.keep));
      check({tag, "_last"}, 512'(g.last), 512'(e.last));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  function automatic logic [511:0] place(input int o, input int n, input logic [31:0] base);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[32*(o+j) +: 32] = base + 32'(j);
    return r;
  endfunction

  function automatic logic [15:0] kmask(input int o, input int n);
    logic [31:0] t;
    t = ((32'd1 << n) - 32'd1) << o;
    return t[15:0];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [511:0] d;
    logic [15:0]  k;
    beat_t        b;
    int           nb;
    int           o;
    int           n;
    bit           lst;

    ARESETN = 1'b0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA = '0;
    S_AXIS_TKEEP = '0;
    S_AXIS_TLAST = 1'b0;
    M_AXIS_TREADY = 1'b1;
    repeat (3) tick();
    check("rst_valid", 512'(M_AXIS_TVALID), 512'(0));
    check("rst_last", 512'(M_AXIS_TLAST), 512'(0));
    check("rst_data", M_AXIS_TDATA, 512'(0));
    check("rst_keep", 512'(M_AXIS_TKEEP), 512'(0));
    check("rst_err", 512'(error_keep_noncontig), 512'(0));
    check("rst_sready", 512'(S_AXIS_TREADY), 512'(0));
    ARESETN = 1'b1;
    tick();
    check("sready_after_rst", 512'(S_AXIS_TREADY), 512'(1));

    // single short TLP, junk in the unused upper lanes must not leak out
    d = {64{8'hA5}};
    send(d, 16'h00FF, 1'b1);
    check("short_valid", 512'(M_AXIS_TVALID), 512'(1));
    check("short_keep", 512'(M_AXIS_TKEEP), 512'(16'h00FF));
    check("short_last", 512'(M_AXIS_TLAST), 512'(1));
    check("short_data", M_AXIS_TDATA, {256'b0, {32{8'hA5}}});
    model_beat(d, 16'h00FF);
    model_end();
    drain("short");

    // three-beat TLP: D0..D7 in lane 10, D8..D23 full, D24..D27 last
    d = place(8, 8, 32'hD000_0000);  send(d, 16'hFF00, 1'b0); model_beat(d, 16'hFF00);
    d = place(0, 16, 32'hD000_0008); send(d, 16'hFFFF, 1'b0); model_beat(d, 16'hFFFF);
    d = place(0, 4, 32'hD000_0018);  send(d, 16'h000F, 1'b1); model_beat(d, 16'h000F);
    model_end();
    check("three_exp_keep", 512'(exp_q[1].keep), 512'(16'h0FFF));
    drain("three");

    // flush: 24 dwords ending on a full beat
    d = place(8, 8, 32'hF000_0000);  send(d, 16'hFF00, 1'b0); model_beat(d, 16'hFF00);
    d = place(0, 16, 32'hF000_0008); send(d, 16'hFFFF, 1'b1); model_beat(d, 16'hFFFF);
    check("flush_sready_lo", 512'(S_AXIS_TREADY), 512'(0));
    tick();
    check("flush_sready_hi", 512'(S_AXIS_TREADY), 512'(1));
    check("flush_tail_keep", 512'(M_AXIS_TKEEP), 512'(16'h00FF));
    model_end();
    drain("flush");

    // backpressure: output held for 5 cycles, input stalled
    M_AXIS_TREADY = 1'b0;
    d = place(0, 4, 32'hB000_0000);
    send(d, 16'h000F, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 512'(M_AXIS_TVALID), 512'(1));
      check("bp_data", M_AXIS_TDATA, d);
      check("bp_keep", 512'(M_AXIS_TKEEP), 512'(16'h000F));
      check("bp_sready", 512'(S_AXIS_TREADY), 512'(0));
      tick();
    end
    model_beat(d, 16'h000F);
    model_end();
    drain("bp");

    // non-contiguous TKEEP: taken as 8 dwords from lane 0
    d = rand512();
    send(d, 16'h0F0F, 1'b1);
    check("nc_err_hi", 512'(error_keep_noncontig), 512'(1));
    check("nc_keep", 512'(M_AXIS_TKEEP), 512'(16'h00FF));
    check("nc_last", 512'(M_AXIS_TLAST), 512'(1));
    check("nc_data", M_AXIS_TDATA, {256'b0, d[255:0]});
    tick();
    check("nc_err_lo", 512'(error_keep_noncontig), 512'(0));
    b.data = {256'b0, d[255:0]};
    b.keep = 16'h00FF;
    b.last = 1'b1;
    exp_q.push_back(b);
    drain("nc");

    // reset mid-packet discards the residue
    send(place(8, 8, 32'hC000_0000), 16'hFF00, 1'b0);
    ARESETN = 1'b0;
    tick();
    check("rmid_valid", 512'(M_AXIS_TVALID), 512'(0));
    check("rmid_data", M_AXIS_TDATA, 512'(0));
    check("rmid_keep", 512'(M_AXIS_TKEEP), 512'(0));
    check("rmid_last", 512'(M_AXIS_TLAST), 512'(0));
    check("rmid_sready", 512'(S_AXIS_TREADY), 512'(0));
    ARESETN = 1'b1;
    d = place(0, 4, 32'hE000_0000);
    send(d, 16'h000F, 1'b1);
    model_beat(d, 16'h000F);
    model_end();
    drain("rmid");

    // random TLPs with random output backpressure
    err_pulses = 0;
    rand_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      nb = $urandom_range(1, 5);
      for (int bi = 0; bi < nb; bi++) begin
        lst = (bi == nb - 1);
        if (!lst && $urandom_range(0, 5) == 0) begin
          o = 0;
          n = 0;
        end else begin
          o = $urandom_range(0, 15);
          n = $urandom_range(1, 16 - o);
        end
        d = rand512();
        k = kmask(o, n);
        model_beat(d, k);
        send(d, k, lst);
        if ($urandom_range(0, 3) == 0) tick();
      end
      model_end();
    end
    drain("rand");
    check("rand_err_pulses", 512'(err_pulses), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tlp_lane_realigner.md
Name: tlp_lane_realigner

Overview:
- Sits directly downstream of the straddle convertor.
- Input is a per-TLP AXI4-Stream: each beat carries one contiguous dword run in lane 00 (dwords 7:0), lane 10 (dwords 15:8), or both, with TLAST marking the TLP end.
- The block shifts and packs these runs into dense 512-bit beats. Every TLP starts at dword 0, all non-final beats are full, and the final beat's TKEEP is contiguous from bit 0.
- This feeds the switch's header decoder/router.

Parameters:
- KEEP_W, 16, number of dwords per beat; data width is 32*KEEP_W. Only 16 is supported.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous active-low reset.
- S_AXIS_TDATA  in  512  input data.
- S_AXIS_TKEEP  in  16  input dword enables.
- S_AXIS_TLAST  in  1  input end of TLP.
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TREADY  out  1  input ready.
- M_AXIS_TDATA  out  512  packed output data.
- M_AXIS_TKEEP  out  16  output dword enables.
- M_AXIS_TLAST  out  1  output end of TLP.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TREADY  in  1  output ready.
- error_keep_noncontig  out  1  one-cycle pulse on an accepted beat with non-contiguous TKEEP.

Behaviour:
- Reset (ARESETN low at ACLK edge):
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TKEEP=0, error_keep_noncontig=0.
  - Residue count R=0; state=RUN.
  - S_AXIS_TREADY forced 0 while ARESETN is low.
- Reset mid-packet discards the residue and any pending output beat. No partial TLP is emitted.
- Accept condition: S_AXIS_TVALID && S_AXIS_TREADY.
- S_AXIS_TREADY = ARESETN && state==RUN && (!M_AXIS_TVALID || M_AXIS_TREADY). It is combinational.
- Per accepted beat:
  - O = index of the lowest set TKEEP bit.
  - N = popcount(TKEEP), range 0..16.
  - Input dwords O..O+N-1 are appended after the R residue dwords, forming a combined vector of C = R+N dwords (C ≤ 31).
- Non-last beat (TLAST=0):
  - C ≥ 16: load the output register with combined dwords 0..15, TKEEP=FFFF, TLAST=0. The residue becomes dwords 16..C-1 and R = C-16.
  - C < 16: no output; R = C.
  - TKEEP=0 is a no-op beat.
- Last beat (TLAST=1):
  - 1 ≤ C ≤ 16: output C dwords, TKEEP=(1<<C)-1, TLAST=1; R=0.
  - C = 0: no output; R=0.
  - C > 16: output dwords 0..15, TKEEP=FFFF, TLAST=0. Residue = C-16 dwords; go to state FLUSH.
- State FLUSH:
  - S_AXIS_TREADY=0.
  - When the output register is free (!M_AXIS_TVALID || M_AXIS_TREADY), load the residue with TKEEP=(1<<R)-1 and TLAST=1. Then R=0 and state returns to RUN on the next cycle.
- Output register:
  - Latency is 1 cycle from the accept that completes a beat to M_AXIS_TVALID=1.
  - TDATA, TKEEP and TLAST stay stable while TVALID=1 and TREADY=0.
  - TVALID drops after a handshake unless a new beat is loaded in the same cycle. Back-to-back output is sustained at 1 beat/cycle.
  - Dwords with TKEEP=0 are driven as zero.
- Simultaneous output handshake and new load in one cycle: the new beat replaces the old one with no bubble.
- Non-contiguous TKEEP (set bits not a single run):
  - error_keep_noncontig=1 for exactly the cycle after the accept.
  - The beat is processed as N dwords starting at O. There is no other recovery.
- Throughput: no input stall except during output backpressure and the single FLUSH cycle.

Test Plan:
- Three-beat TLP:
  - Stimulus: TKEEP=FF00 (D0..D7), then FFFF (D8..D23), then 000F TLAST=1 (D24..D27); M_AXIS_TREADY=1.
  - Response: beat1 D0..D15 TKEEP=FFFF TLAST=0; beat2 D16..D27 TKEEP=0FFF TLAST=1.
- Flush case:
  - Stimulus: TKEEP=FF00, then FFFF TLAST=1.
  - Response: beat D0..D15 TLAST=0, then D16..D23 TKEEP=00FF TLAST=1. S_AXIS_TREADY=0 for exactly one cycle.
- Single short TLP:
  - Stimulus: TKEEP=00FF TLAST=1, data 0xA5 pattern.
  - Response: one cycle later M_AXIS_TVALID=1, TKEEP=00FF, TLAST=1, upper 256 bits zero.
- Backpressure:
  - Stimulus: M_AXIS_TREADY=0 for 5 cycles while an output beat is valid.
  - Response: output held bit-stable, S_AXIS_TREADY=0, no beat lost or duplicated after release.
- Non-contiguous TKEEP:
  - Stimulus: TKEEP=0F0F TLAST=1.
  - Response: error_keep_noncontig high exactly 1 cycle; output TKEEP=00FF TLAST=1.
- Reset mid-packet:
  - Stimulus: ARESETN low for 1 cycle after TKEEP=FF00 with TLAST=0.
  - Response: all outputs zero, next TLP TKEEP=000F TLAST=1 outputs TKEEP=000F containing only new data.
